// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package boot_pkg;

  // Loader state machine encoding.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } boot_state_e;

  // Default frame start byte.
  localparam logic [7:0] BOOT_MAGIC = 8'hA5;

  // Frame field widths: word count and checksum.
  localparam int COUNT_W = 16;
  localparam int CSUM_W  = 8;

endpackage

// File: rtl/boot_word_assembler.sv
// Little-endian byte-to-word assembler: each byte enters at [31:24] and
// shifts down, so after four bytes the first one sits in [7:0].
module boot_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  logic [31:0] word_d;

  // Next word value includes the byte being accepted this cycle, so the
  // complete word is available in the same cycle as the 4th byte.
  assign word_d      = {byte_i, word_q[31:8]};
  assign word_o      = word_d;
  assign word_done_o = byte_valid_i && (cnt_q == 2'd3);

  // Shift register and byte counter; clear realigns at the start of a payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clear_i) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (byte_valid_i) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the instruction memory. Holds the core in
// reset until a full frame with a matching checksum has been written.
//
// Handshake: a byte is transferred on any rising edge where s_valid and
// s_ready are both high. s_ready depends on the current state only (low
// solely in DONE) and never on s_valid; the sender must hold s_data stable
// while s_valid is high and the byte has not been taken.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [7:0] MAGIC  = BOOT_MAGIC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [2:0]  state_dbg
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  boot_state_e         state_q;
  logic [7:0]          len_lo_q;
  logic [COUNT_W-1:0]  n_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [CSUM_W-1:0]   csum_q;
  logic [CSUM_W-1:0]   csum_d;
  logic                imem_we_q;
  logic [31:0]         imem_addr_q;
  logic [31:0]         imem_wd_q;
  logic                core_hold_q;
  logic                done_q;
  logic                error_q;

  logic                accept;
  logic [COUNT_W-1:0]  n_in;
  logic                last_word;
  logic                asm_clear;
  logic                asm_valid;
  logic [31:0]         asm_word;
  logic                asm_done;

  assign s_ready   = (state_q != S_DONE);
  assign accept    = s_valid && s_ready;
  assign n_in      = {s_data, len_lo_q};
  assign csum_d    = csum_q + s_data;
  assign last_word = (int'(idx_q) + 1) == int'(n_q);
  assign asm_clear = accept && (state_q == S_LEN_HI);
  assign asm_valid = accept && (state_q == S_DATA);

  assign imem_we   = imem_we_q;
  assign imem_addr = imem_addr_q;
  assign imem_wd   = imem_wd_q;
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign error     = error_q;
  assign state_dbg = state_q;

  boot_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (s_data),
    .word_o       (asm_word),
    .word_done_o  (asm_done)
  );

  // Frame state machine with registered write port and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_lo_q    <= 8'd0;
      n_q         <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= 32'd0;
      imem_wd_q   <= 32'd0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_IDLE: begin
            if (s_data == MAGIC) state_q <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_lo_q <= s_data;
            state_q  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            n_q    <= n_in;
            idx_q  <= '0;
            csum_q <= '0;
            if (int'(n_in) > MAX_WORDS) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end else if (n_in == '0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            // MAGIC here is ordinary payload.
            csum_q <= csum_d;
            if (asm_done) begin
              imem_we_q   <= 1'b1;
              imem_addr_q <= 32'({idx_q, 2'b00});
              imem_wd_q   <= asm_word;
              idx_q       <= idx_q + 1'b1;
              if (last_word) state_q <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (s_data == csum_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              core_hold_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
          S_ERR: begin
            if (s_data == MAGIC) begin
              error_q <= 1'b0;
              state_q <= S_LEN_LO;
            end
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a frame-level reference model
// and a per-cycle write scoreboard.
module tb_imem_boot_loader;

  localparam int ADDR_W = 10;

  logic        clk;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [2:0]  state_dbg;

  int tests_run;
  int tests_failed;
  int cyc;
  int we_count;
  logic [31:0] last_addr;

  // Expected writes: {byte address, data}.
  logic [63:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [31:0] words_q[$];
  bit          m_done;
  bit          m_err;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .core_hold (core_hold),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_vs_done", {63'd0, s_ready}, {63'd0, !done});
      check("hold_vs_done", {63'd0, core_hold}, {63'd0, !done});
      if (imem_we) begin
        we_count++;
        last_addr = imem_addr;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {imem_addr, imem_wd}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("write", {imem_addr, imem_wd}, exp_q.pop_front());
        end
      end
    end
  end

  // Frame builder: header, little-endian payload, payload sum + csum_delta.
  task automatic build_frame(input logic [7:0] csum_delta);
    logic [7:0]  sum;
    logic [15:0] n;
    logic [31:0] w;
    frame_q.delete();
    n = 16'(words_q.size());
    sum = 8'd0;
    frame_q.push_back(8'hA5);
    frame_q.push_back(n[7:0]);
    frame_q.push_back(n[15:8]);
    foreach (words_q[i]) begin
      w = words_q[i];
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(w[8*b +: 8]);
        sum = sum + w[8*b +: 8];
      end
    end
    frame_q.push_back(sum + csum_delta);
  endtask

  // Reference model: parse a byte stream and predict writes and outcome.
  task automatic model_frame();
    int p;
    int n;
    logic [7:0]  sum;
    logic [31:0] w;
    p = 0;
    m_done = 0;
    m_err = 0;
    while (p < frame_q.size() && frame_q[p] != 8'hA5) p++;
    if (p + 2 >= frame_q.size()) return;
    n = int'({frame_q[p+2], frame_q[p+1]});
    p = p + 3;
    if (n > (1 << ADDR_W)) begin
      m_err = 1;
      return;
    end
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = {frame_q[p+3], frame_q[p+2], frame_q[p+1], frame_q[p]};
      sum = sum + frame_q[p] + frame_q[p+1] + frame_q[p+2] + frame_q[p+3];
      exp_q.push_back({32'(i * 4), w});
      p = p + 4;
    end
    if (frame_q[p] == sum) m_done = 1;
    else m_err = 1;
  endtask

  // Driver: present one byte, optionally after random idle cycles.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) begin
      while ($urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data  = b;
    guard   = 0;
    while (!s_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!s_ready) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit stall);
    for (int i = lo; i <= hi; i++) send_byte(frame_q[i], stall);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    we_count = 0;
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, {63'd0, s_ready}, 64'd1);
    check({tag, "_imem_we"}, {63'd0, imem_we}, 64'd0);
    check({tag, "_imem_addr"}, {32'd0, imem_addr}, 64'd0);
    check({tag, "_imem_wd"}, {32'd0, imem_wd}, 64'd0);
    check({tag, "_core_hold"}, {63'd0, core_hold}, 64'd1);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_error"}, {63'd0, error}, 64'd0);
  endtask

  task automatic finish_frame_checks(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done"}, {63'd0, done}, {63'd0, m_done});
    check({tag, "_error"}, {63'd0, error}, {63'd0, m_err});
    check({tag, "_hold"}, {63'd0, core_hold}, {63'd0, !m_done});
  endtask

  initial begin
    int t0;
    int last;
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    we_count = 0;
    last_addr = 32'd0;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'd0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("after_reset");

    // Frame A: nop and addi x1,x0,1; payload sum is 0xB6.
    words_q = '{32'h0000_0013, 32'h0010_0093};
    build_frame(8'd0);
    check("pin_csum", 64'(frame_q[11]), 64'hB6);
    model_frame();
    check("pin_exp0", exp_q[0], 64'h0000_0000_0000_0013);
    check("pin_exp1", exp_q[1], 64'h0000_0004_0010_0093);
    t0 = cyc;
    send_range(0, 6, 0);
    check("we_latency", {63'd0, imem_we}, 64'd1);
    send_range(7, 10, 0);
    check("done_before_csum", {63'd0, done}, 64'd0);
    send_range(11, 11, 0);
    check("done_after_csum", {63'd0, done}, 64'd1);
    check("hold_after_csum", {63'd0, core_hold}, 64'd0);
    check("cycles_to_done", 64'(cyc - t0), 64'd12);
    check("a_we_count", 64'(we_count), 64'd2);
    finish_frame_checks("a");
    check("done_sticky_ready", {63'd0, s_ready}, 64'd0);

    // Bad checksum (0xBA), then a good frame recovers.
    do_reset();
    build_frame(8'h04);
    check("pin_bad_csum", 64'(frame_q[11]), 64'hBA);
    model_frame();
    send_range(0, 11, 0);
    check("bad_error", {63'd0, error}, 64'd1);
    check("bad_we_count", 64'(we_count), 64'd2);
    finish_frame_checks("bad");
    build_frame(8'd0);
    model_frame();
    send_range(0, 0, 0);
    check("error_cleared_by_magic", {63'd0, error}, 64'd0);
    send_range(1, 11, 0);
    finish_frame_checks("recover");

    // Oversized length 0x0401.
    do_reset();
    frame_q = '{8'hA5, 8'h01, 8'h04};
    model_frame();
    send_range(0, 2, 0);
    check("len_error", {63'd0, error}, 64'd1);
    check("len_ready", {63'd0, s_ready}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("len_we_count", 64'(we_count), 64'd0);
    finish_frame_checks("len");

    // 16-word frame, no stalls then random stalls.
    do_reset();
    words_q.delete();
    for (int i = 0; i < 16; i++) words_q.push_back($urandom());
    words_q[3] = 32'hA5A5_A5A5;
    build_frame(8'd0);
    model_frame();
    t0 = cyc;
    send_range(0, frame_q.size() - 1, 0);
    check("cycles16", 64'(cyc - t0), 64'd68);
    check("nostall_we_count", 64'(we_count), 64'd16);
    finish_frame_checks("nostall");
    do_reset();
    model_frame();
    send_range(0, frame_q.size() - 1, 1);
    check("stall_we_count", 64'(we_count), 64'd16);
    finish_frame_checks("stall");

    // Leading junk before MAGIC, then a 1-word frame.
    do_reset();
    words_q = '{32'hDEAD_BEEF};
    build_frame(8'd0);
    frame_q.push_front(8'h5A);
    frame_q.push_front(8'hFF);
    frame_q.push_front(8'h00);
    model_frame();
    send_range(0, frame_q.size() - 1, 0);
    check("junk_addr", {32'd0, last_addr}, 64'd0);
    finish_frame_checks("junk");

    // Maximum length: last write at byte address 0xFFC.
    do_reset();
    words_q.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) words_q.push_back(32'(i * 32'h0101_0101));
    build_frame(8'd0);
    model_frame();
    send_range(0, frame_q.size() - 1, 0);
    check("max_last_addr", {32'd0, last_addr}, 64'h0000_0FFC);
    check("max_we_count", 64'(we_count), 64'd1024);
    finish_frame_checks("max");

    // Reset after 6 payload bytes, then a full frame.
    do_reset();
    words_q = '{32'h1122_3344, 32'h5566_7788};
    build_frame(8'd0);
    model_frame();
    send_range(0, 8, 0);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    check("midrst_pending", 64'(exp_q.size()), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    we_count = 0;
    exp_q.delete();
    model_frame();
    send_range(0, frame_q.size() - 1, 0);
    check("midrst_we_count", 64'(we_count), 64'd2);
    check("midrst_last_addr", {32'd0, last_addr}, 64'h4);
    finish_frame_checks("midrst");

    last = tests_failed;
    $display("[TB] %0d tests run, %0d failed", tests_run, last);
    $finish;
  end

endmodule
